// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch constants and the fetch FSM states.
package mips_pkg;

  // sll $0,$0,0 encodes as all zeroes
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] PC_ALIGN = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory bus and IF/ID outputs.
interface if_stage_if;
  import mips_pkg::*;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        halted;

  // Fetch-stage side
  modport master (
    input  stall, redirect, redirect_pc, halt, imem_instr,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, halted
  );

  // Surrounding pipeline / memory side
  modport slave (
    output stall, redirect, redirect_pc, halt, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, halted
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and fetch FSM.
// Instruction memory is combinational and lives outside this block.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic          clk,
  input  logic          reset,
  if_stage_if.master    bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_q + PC_STEP;

  // Next-state selection: redirect beats halt and stall, stall beats advance
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      BOOT: begin
        // One idle cycle after reset release; nothing is fetched
        state_d = RUN;
      end
      RUN: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc & PC_ALIGN;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (bus.halt) begin
          // Halt freezes everything on this edge, including a stalled IF/ID
          state_d = HALTED;
        end else if (!bus.stall) begin
          pc_d    = pc_plus4;
          instr_d = bus.imem_instr;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
        end
      end
      HALTED: begin
        // Drain IF/ID to a bubble; redirect and stall have no effect here
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC & PC_ALIGN;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.if_id_instr = instr_q;
    bus.if_id_pc4   = pc4_q;
    bus.if_id_valid = valid_q;
    bus.fetch_count = count_q;
    bus.halted      = (state_q == HALTED);
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: two instances (normal and wrap-around reset PC) share one
// 256-word instruction memory and one randomized stimulus stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  if_stage_if bus0 ();
  if_stage_if bus1 ();

  assign bus0.stall       = stall;
  assign bus0.redirect    = redirect;
  assign bus0.redirect_pc = redirect_pc;
  assign bus0.halt        = halt;
  assign bus0.imem_instr  = mem[bus0.imem_addr[9:2]];
  assign bus1.stall       = stall;
  assign bus1.redirect    = redirect;
  assign bus1.redirect_pc = redirect_pc;
  assign bus1.halt        = halt;
  assign bus1.imem_instr  = mem[bus1.imem_addr[9:2]];

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Architectural view of the fetch stage
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] count;
    bit          valid;
    bit          halted;
    bit          booting;
    bit          pc4_known;
  } model_t;

  typedef struct {
    model_t a;
    model_t b;
  } exp_t;

  exp_t   exp_q [$];
  model_t m0, m1;
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic model_t step(model_t s, bit r, bit st, bit rd, logic [31:0] rpc, bit h,
                                  logic [31:0] rst_pc);
    model_t n = s;
    if (r) begin
      n.pc = rst_pc; n.instr = 32'h0; n.pc4 = 32'h0; n.count = 32'h0;
      n.valid = 0; n.halted = 0; n.booting = 1; n.pc4_known = 1;
    end else if (s.booting) begin
      n.booting = 0;
    end else if (s.halted) begin
      n.instr = 32'h0; n.valid = 0;
    end else if (rd) begin
      n.pc = {rpc[31:2], 2'b00}; n.instr = 32'h0; n.valid = 0; n.pc4_known = 0;
    end else if (h) begin
      n.halted = 1;
    end else if (!st) begin
      n.instr = mem[s.pc[9:2]];
      n.pc = s.pc + 32'd4;
      n.pc4 = n.pc;
      n.count = s.count + 32'd1;
      n.valid = 1; n.pc4_known = 1;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: after every edge, compare both DUTs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dut0.imem_addr", bus0.imem_addr, e.a.pc);
        chk("dut0.if_id_instr", bus0.if_id_instr, e.a.instr);
        chk("dut0.if_id_valid", {31'h0, bus0.if_id_valid}, {31'h0, e.a.valid});
        chk("dut0.fetch_count", bus0.fetch_count, e.a.count);
        chk("dut0.halted", {31'h0, bus0.halted}, {31'h0, e.a.halted});
        if (e.a.pc4_known) chk("dut0.if_id_pc4", bus0.if_id_pc4, e.a.pc4);
        chk("dut1.imem_addr", bus1.imem_addr, e.b.pc);
        chk("dut1.if_id_instr", bus1.if_id_instr, e.b.instr);
        chk("dut1.if_id_valid", {31'h0, bus1.if_id_valid}, {31'h0, e.b.valid});
        chk("dut1.fetch_count", bus1.fetch_count, e.b.count);
        chk("dut1.halted", {31'h0, bus1.halted}, {31'h0, e.b.halted});
        if (e.b.pc4_known) chk("dut1.if_id_pc4", bus1.if_id_pc4, e.b.pc4);
      end
    end
  end

  // Drive one cycle of inputs and queue what both stages must show after the edge
  task automatic cyc(bit r, bit st, bit rd, logic [31:0] rpc, bit h);
    exp_t e;
    @(negedge clk);
    reset = r; stall = st; redirect = rd; redirect_pc = rpc; halt = h;
    m0 = step(m0, r, st, rd, rpc, h, 32'h0000_0000);
    m1 = step(m1, r, st, rd, rpc, h, 32'hFFFF_FFFC);
    e.a = m0;
    e.b = m1;
    exp_q.push_back(e);
  endtask

  initial begin
    bit r, st, rd, h;
    logic [31:0] rpc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0] = 32'h8C01_0000;
    mem[1] = 32'h0021_1020;
    mem[2] = 32'hAC02_0004;
    mem[3] = 32'h1021_FFFF;

    // Reset, boot, free run, load-use stall
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    // Redirect together with stall, then halt and ignored pulses
    cyc(0, 1, 1, 32'h0000_000E, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 1, 32'h0000_0040, 0);
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    // Halt with stall, halt with redirect, reset during stall/redirect
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 32'hFFFF_FFF8, 1);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(1, 1, 1, 32'h0000_0100, 0);
    cyc(0, 0, 0, 32'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 149) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      h   = ($urandom_range(0, 59) == 0);
      rpc = $urandom_range(0, 1) ? $urandom() : {22'h3FFFFF, 10'($urandom())};
      cyc(r, st, rd, rpc, h);
    end
    cyc(0, 0, 0, 32'h0, 0);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
